// File: rtl/ranger_pkg.sv
// Shared types and constants for the ultrasonic ranger.
// Echo-width bins map onto 400 Hz PWM compare values.
package ranger_pkg;

   localparam int PWM_W  = 19;
   localparam int ECHO_W = 23;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_TRIG,
      ST_WAIT_RISE,
      ST_MEASURE
   } state_e;

   localparam int BIN_THR0 = 475250;
   localparam int BIN_THR1 = 950500;
   localparam int BIN_THR2 = 1425750;

   localparam logic [PWM_W-1:0] DUTY_0 = 19'd62500;
   localparam logic [PWM_W-1:0] DUTY_1 = 19'd125000;
   localparam logic [PWM_W-1:0] DUTY_2 = 19'd187500;
   localparam logic [PWM_W-1:0] DUTY_3 = 19'd250000;

   function automatic logic [PWM_W-1:0] bin_duty(
      input logic [ECHO_W-1:0] w,
      input logic [ECHO_W-1:0] t0,
      input logic [ECHO_W-1:0] t1,
      input logic [ECHO_W-1:0] t2
   );
      if (w <= t0)      return DUTY_0;
      else if (w <= t1) return DUTY_1;
      else if (w <= t2) return DUTY_2;
      else              return DUTY_3;
   endfunction

endpackage

// File: rtl/ultrasonic_ranger_if.sv
// Sensor pins and PWM-stage outputs of the ranger.
// master: the ranger itself; slave: the consumer/sensor side.
interface ultrasonic_ranger_if;

   logic                            echo;
   logic                            trig;
   logic [ranger_pkg::PWM_W-1:0]    pulse_width;
   logic [ranger_pkg::ECHO_W-1:0]   echo_cycles;
   logic                            meas_valid;
   logic                            timeout;

   modport master (
      input  echo,
      output trig, pulse_width, echo_cycles, meas_valid, timeout
   );

   modport slave (
      output echo,
      input  trig, pulse_width, echo_cycles, meas_valid, timeout
   );

endinterface

// File: rtl/echo_sync.sv
// 2-flop echo synchroniser; ECHO_DEGLITCH_EN adds a 4-cycle
// stable-level filter after the synchroniser.
module echo_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic i_echo,
   output logic o_echo_s
);

   logic r_meta;
   logic r_sync;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= 1'b0;
         r_sync <= 1'b0;
      end else begin
         r_meta <= i_echo;
         r_sync <= r_meta;
      end
   end

`ifdef ECHO_DEGLITCH_EN
   logic       r_filt;
   logic [1:0] r_hold;

   // r_hold counts consecutive cycles the synced level differs from r_filt
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_filt <= 1'b0;
         r_hold <= 2'd0;
      end else if (r_sync == r_filt) begin
         r_hold <= 2'd0;
      end else if (r_hold == 2'd3) begin
         r_filt <= r_sync;
         r_hold <= 2'd0;
      end else begin
         r_hold <= r_hold + 2'd1;
      end
   end

   assign o_echo_s = r_filt;
`else
   assign o_echo_s = r_sync;
`endif

endmodule

// File: rtl/ultrasonic_ranger.sv
// HC-SR04 ranger: periodic trigger, echo timing, PWM bin mapping.
// Optional ECHO_DEGLITCH_EN enables the echo deglitch filter.
module ultrasonic_ranger
   import ranger_pkg::*;
#(
   parameter int TRIG_CYCLES   = 1000,
   parameter int RISE_TIMEOUT  = 2_500_000,
   parameter int ECHO_TIMEOUT  = 3_802_000,
   parameter int PERIOD_CYCLES = 10_000_000,
   parameter int BIN_T0        = BIN_THR0,
   parameter int BIN_T1        = BIN_THR1,
   parameter int BIN_T2        = BIN_THR2
) (
   input logic                 clk,
   input logic                 rst_n,
   ultrasonic_ranger_if.master bus
);

   localparam int CW = $clog2(PERIOD_CYCLES + 1);

   if (TRIG_CYCLES + RISE_TIMEOUT + ECHO_TIMEOUT >= PERIOD_CYCLES)
   begin : g_param_chk
      $error("ultrasonic_ranger: trig+rise+echo must fit in period");
   end

   logic w_echo_s;
   logic w_rise;

   state_e              r_state;
   logic [CW-1:0]       r_pcnt;
   logic [CW-1:0]       r_cnt;
   logic [ECHO_W-1:0]   r_ecnt;
   logic                r_echo_d;
   logic                r_trig;
   logic [PWM_W-1:0]    r_pw;
   logic [ECHO_W-1:0]   r_ecyc;
   logic                r_valid;
   logic                r_tmo;

   echo_sync u_echo_sync (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_echo   (bus.echo),
      .o_echo_s (w_echo_s)
   );

   // a level already high on entry to WAIT_RISE is not an edge
   assign w_rise = w_echo_s & ~r_echo_d;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state  <= ST_IDLE;
         r_pcnt   <= '0;
         r_cnt    <= '0;
         r_ecnt   <= '0;
         r_echo_d <= 1'b0;
         r_trig   <= 1'b0;
         r_pw     <= '0;
         r_ecyc   <= '0;
         r_valid  <= 1'b0;
         r_tmo    <= 1'b0;
      end else begin
         r_echo_d <= w_echo_s;
         r_valid  <= 1'b0;
         if (r_pcnt == CW'(PERIOD_CYCLES - 1)) r_pcnt <= '0;
         else                                  r_pcnt <= r_pcnt + CW'(1);

         unique case (r_state)
            ST_IDLE: begin
               if (r_pcnt == '0) begin
                  r_state <= ST_TRIG;
                  r_trig  <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            ST_TRIG: begin
               if (r_cnt == CW'(TRIG_CYCLES - 1)) begin
                  r_state <= ST_WAIT_RISE;
                  r_trig  <= 1'b0;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_WAIT_RISE: begin
               if (w_rise) begin
                  r_state <= ST_MEASURE;
                  r_ecnt  <= ECHO_W'(1);
               end else if (r_cnt == CW'(RISE_TIMEOUT - 1)) begin
                  r_state <= ST_IDLE;
                  r_tmo   <= 1'b1;
               end else begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_MEASURE: begin
               // reaching the limit wins even if echo falls this cycle
               if (r_ecnt == ECHO_W'(ECHO_TIMEOUT)) begin
                  r_state <= ST_IDLE;
                  r_tmo   <= 1'b1;
               end else if (!w_echo_s) begin
                  r_state <= ST_IDLE;
                  r_ecyc  <= r_ecnt;
                  r_pw    <= bin_duty(r_ecnt,
                                      ECHO_W'(BIN_T0),
                                      ECHO_W'(BIN_T1),
                                      ECHO_W'(BIN_T2));
                  r_valid <= 1'b1;
                  r_tmo   <= 1'b0;
               end else begin
                  r_ecnt <= r_ecnt + ECHO_W'(1);
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign bus.trig        = r_trig;
   assign bus.pulse_width = r_pw;
   assign bus.echo_cycles = r_ecyc;
   assign bus.meas_valid  = r_valid;
   assign bus.timeout     = r_tmo;

endmodule

// File: tb/tb_ultrasonic_ranger.sv
// Bench for ultrasonic_ranger with time-scaled parameters.
// Expected events come from pulse start/width arithmetic.
module tb_ultrasonic_ranger;

   localparam int TRIG = 10;
   localparam int RISE = 250;
   localparam int ECHO = 380;
   localparam int PER  = 1000;
   localparam int T0   = 47;
   localparam int T1   = 95;
   localparam int T2   = 142;
`ifdef ECHO_DEGLITCH_EN
   localparam int L = 6;
`else
   localparam int L = 2;
`endif

   typedef struct {
      int at;
      bit ok;
      int w;
   } ev_t;

   logic clk = 1'b0;
   logic rst_n;
   int   cyc;
   int   checks = 0;
   int   failures = 0;
   ev_t  evq[$];
   ev_t  e;
   bit   v;
   int   m_pw = 0;
   int   m_ec = 0;
   bit   m_to = 1'b0;

   ultrasonic_ranger_if bus ();

   ultrasonic_ranger #(
      .TRIG_CYCLES   (TRIG),
      .RISE_TIMEOUT  (RISE),
      .ECHO_TIMEOUT  (ECHO),
      .PERIOD_CYCLES (PER),
      .BIN_T0        (T0),
      .BIN_T1        (T1),
      .BIN_T2        (T2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   always @(posedge clk or negedge rst_n)
      if (!rst_n) cyc <= 0;
      else        cyc <= cyc + 1;

   function automatic int duty(input int w);
      if (w <= T0)      return 62500;
      else if (w <= T1) return 125000;
      else if (w <= T2) return 187500;
      else              return 250000;
   endfunction

   function automatic bit exp_trig(input int n);
      return (n >= 1) && (((n - 1) % PER) < TRIG);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0d expected %0d at cyc %0d",
                  nm, act, exp, cyc);
      end
   endtask

   task automatic sched(input int at, input bit ok, input int w);
      ev_t x;
      x.at = at;
      x.ok = ok;
      x.w  = w;
      evq.push_back(x);
   endtask

   task automatic model_reset();
      evq.delete();
      m_pw = 0;
      m_ec = 0;
      m_to = 1'b0;
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         chk("rst_trig", 32'(bus.trig), 0);
         chk("rst_pw", 32'(bus.pulse_width), 0);
         chk("rst_ec", 32'(bus.echo_cycles), 0);
         chk("rst_valid", 32'(bus.meas_valid), 0);
         chk("rst_to", 32'(bus.timeout), 0);
      end else begin
         v = 1'b0;
         if (evq.size() > 0 && evq[0].at == cyc) begin
            e = evq.pop_front();
            if (e.ok) begin
               v    = 1'b1;
               m_ec = e.w;
               m_pw = duty(e.w);
               m_to = 1'b0;
            end else begin
               m_to = 1'b1;
            end
         end
         chk("trig", 32'(bus.trig), 32'(exp_trig(cyc)));
         chk("meas_valid", 32'(bus.meas_valid), 32'(v));
         chk("pulse_width", 32'(bus.pulse_width), m_pw);
         chk("echo_cycles", 32'(bus.echo_cycles), m_ec);
         chk("timeout", 32'(bus.timeout), 32'(m_to));
      end
   end

   task automatic wait_neg(input int n);
      while (cyc < n) @(negedge clk);
   endtask

   task automatic release_rst();
      repeat (3) @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic hit_reset(input string tag);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk({tag, "_trig"}, 32'(bus.trig), 0);
      chk({tag, "_pw"}, 32'(bus.pulse_width), 0);
      chk({tag, "_ec"}, 32'(bus.echo_cycles), 0);
      chk({tag, "_to"}, 32'(bus.timeout), 0);
      bus.echo = 1'b0;
      model_reset();
      release_rst();
   endtask

   // w = 0: no echo; rise lands 40 cycles after trig falls
   task automatic attempt(input int p, input int w);
      int r;
      r = p + TRIG + 40;
      if (w == 0)         sched(p + TRIG + RISE, 1'b0, 0);
      else if (w >= ECHO) sched(r + ECHO, 1'b0, 0);
      else                sched(r + w, 1'b1, w);
      if (w > 0) begin
         wait_neg(r - L - 1);
         bus.echo = 1'b1;
         wait_neg(r - L - 1 + w);
         bus.echo = 1'b0;
      end
      wait_neg(p + PER - 1);
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: run did not complete, cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int p;
      bus.echo = 1'b0;
      rst_n    = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("init_trig", 32'(bus.trig), 0);
      chk("init_pw", 32'(bus.pulse_width), 0);
      release_rst();

      sched(1 + TRIG + RISE, 1'b0, 0);
      wait_neg(1);
      chk("trig_first", 32'(bus.trig), 1);
      wait_neg(TRIG);
      chk("trig_last", 32'(bus.trig), 1);
      wait_neg(TRIG + 1);
      chk("trig_fall", 32'(bus.trig), 0);
      wait_neg(TRIG + RISE);
      chk("to_before", 32'(bus.timeout), 0);
      wait_neg(TRIG + RISE + 1);
      chk("to_rise", 32'(bus.timeout), 1);
      chk("to_pw", 32'(bus.pulse_width), 0);
      wait_neg(PER);

      p = 1 + PER;
      attempt(p, 30);
      chk("w30_ec", 32'(bus.echo_cycles), 30);
      chk("w30_pw", 32'(bus.pulse_width), 62500);
      chk("w30_to", 32'(bus.timeout), 0);
      p += PER;
      attempt(p, 143);
      chk("w143_pw", 32'(bus.pulse_width), 250000);
      p += PER;
      attempt(p, 47);
      chk("w47_pw", 32'(bus.pulse_width), 62500);
      p += PER;
      attempt(p, 48);
      chk("w48_pw", 32'(bus.pulse_width), 125000);
      p += PER;
      attempt(p, 400);
      chk("w400_to", 32'(bus.timeout), 1);
      chk("w400_pw", 32'(bus.pulse_width), 125000);
      chk("w400_ec", 32'(bus.echo_cycles), 48);
      p += PER;
      attempt(p, 60);
      chk("w60_to", 32'(bus.timeout), 0);
      chk("w60_pw", 32'(bus.pulse_width), 125000);
      p += PER;
      attempt(p, ECHO - 1);
      chk("wmax_ec", 32'(bus.echo_cycles), ECHO - 1);
      p += PER;
      attempt(p, ECHO);
      chk("wlim_to", 32'(bus.timeout), 1);
      chk("wlim_ec", 32'(bus.echo_cycles), ECHO - 1);

      p += PER;
      wait_neg(p + TRIG / 2);
      hit_reset("rst_trig");
      attempt(1, 100);
      chk("restart_pw", 32'(bus.pulse_width), 187500);

      p = 1 + PER;
      wait_neg(p + TRIG + 40 - L - 1);
      bus.echo = 1'b1;
      wait_neg(p + TRIG + 70);
      hit_reset("rst_meas");
      attempt(1, 90);
      chk("w90_pw", 32'(bus.pulse_width), 125000);

`ifdef ECHO_DEGLITCH_EN
      p = 1 + PER;
      wait_neg(p + 20);
      bus.echo = 1'b1;
      wait_neg(p + 22);
      bus.echo = 1'b0;
      attempt(p, 90);
      chk("glitch_ec", 32'(bus.echo_cycles), 90);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
